// File: rtl/cpu_datapath.sv
// ============================================================================
// cpu_datapath: state/PC/IR/A/B/ALU/ZF/MDR datapath driven by the control word
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_datapath #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        next_state,
  input  logic              pc_we,
  input  logic              pc_sel,
  input  logic [3:0]        pc_offset,
  input  logic              addr_sel,
  input  logic [3:0]        addr_offset,
  input  logic              mem_sel,
  input  logic              mem_we_in,
  input  logic [2:0]        alu_opcode,
  input  logic              alu_sel_a,
  input  logic              alu_sel_b,
  input  logic              alu_we,
  input  logic              zf_we,
  input  logic              ir_we,
  input  logic              a_sel,
  input  logic              a_we,
  input  logic              b_sel,
  input  logic              b_we,
  input  logic              halt,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic [7:0]        instr,
  output logic [2:0]        state,
  output logic              zf,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        reg_a,
  output logic [7:0]        reg_b,
  output logic              halted
);

  localparam logic [2:0]        c_STATE_FETCH = 3'b000;
  localparam logic [2:0]        c_ALU_ADD     = 3'b000;
  localparam logic [2:0]        c_ALU_AND     = 3'b001;
  localparam logic [2:0]        c_ALU_NOT     = 3'b010;
  localparam logic [ADDR_W-1:0] c_PC_ONE      = ADDR_W'(1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir;
  logic [7:0]        r_a;
  logic [7:0]        r_b;
  logic [7:0]        r_alu_out;
  logic [7:0]        r_mdr;
  logic              r_zf;
  logic              r_halted;

  logic [ADDR_W-1:0] w_pc_sext_off;
  logic [ADDR_W-1:0] w_addr_sext_off;
  logic [ADDR_W-1:0] w_pc_next;
  logic [7:0]        w_op_a;
  logic [7:0]        w_op_b;
  logic [7:0]        w_alu_res;

  // Offsets are 4-bit two's complement; sums wrap naturally at ADDR_W bits.
  assign w_pc_sext_off   = {{(ADDR_W-4){pc_offset[3]}}, pc_offset};
  assign w_addr_sext_off = {{(ADDR_W-4){addr_offset[3]}}, addr_offset};
  assign w_pc_next       = pc_sel ? (r_pc + w_pc_sext_off) : (r_pc + c_PC_ONE);

  assign mem_addr  = addr_sel ? (r_pc + w_addr_sext_off) : r_pc;
  assign mem_wdata = mem_sel ? r_b : r_a;
  assign mem_we    = mem_we_in & ~reset & ~r_halted;

  assign w_op_a = alu_sel_a ? r_b : r_a;
  assign w_op_b = alu_sel_b ? r_b : r_a;

  always_comb begin
    w_alu_res = 8'h00;
    case (alu_opcode)
      c_ALU_ADD: w_alu_res = w_op_a + w_op_b;
      c_ALU_AND: w_alu_res = w_op_a & w_op_b;
      c_ALU_NOT: w_alu_res = ~w_op_a;
      default:   w_alu_res = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_STATE_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= 8'h00;
      r_a       <= 8'h00;
      r_b       <= 8'h00;
      r_alu_out <= 8'h00;
      r_mdr     <= 8'h00;
      r_zf      <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state <= next_state;
      r_mdr   <= mem_rdata;
      if (halt) begin
        r_halted <= 1'b1;
      end
      // Once halted, architectural state is frozen; state and MDR keep tracking.
      if (!r_halted) begin
        if (pc_we)  r_pc      <= w_pc_next;
        if (ir_we)  r_ir      <= mem_rdata;
        if (alu_we) r_alu_out <= w_alu_res;
        if (zf_we)  r_zf      <= (w_alu_res == 8'h00);
        if (a_we)   r_a       <= a_sel ? r_alu_out : r_mdr;
        if (b_we)   r_b       <= b_sel ? r_alu_out : r_mdr;
      end
    end
  end

  assign instr  = r_ir;
  assign state  = r_state;
  assign zf     = r_zf;
  assign pc     = r_pc;
  assign reg_a  = r_a;
  assign reg_b  = r_b;
  assign halted = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath with an external 256-byte memory model.
`default_nettype none

module tb_cpu_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] next_state;
  logic       pc_we, pc_sel, addr_sel, mem_sel, mem_we_in;
  logic [3:0] pc_offset, addr_offset;
  logic [2:0] alu_opcode;
  logic       alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
  logic       a_sel, a_we, b_sel, b_we, halt;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr, mem_wdata, instr, pc, reg_a, reg_b;
  logic       mem_we, zf, halted;
  logic [2:0] state;

  logic [7:0] mem [0:255];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = 8'h00, tb_data = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr]  <= tb_data;
  end

  cpu_datapath dut (
    .clk(clk), .reset(reset), .next_state(next_state),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_offset(pc_offset),
    .addr_sel(addr_sel), .addr_offset(addr_offset),
    .mem_sel(mem_sel), .mem_we_in(mem_we_in), .alu_opcode(alu_opcode),
    .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b),
    .alu_we(alu_we), .zf_we(zf_we), .ir_we(ir_we),
    .a_sel(a_sel), .a_we(a_we), .b_sel(b_sel), .b_we(b_we),
    .halt(halt), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .instr(instr), .state(state),
    .zf(zf), .pc(pc), .reg_a(reg_a), .reg_b(reg_b), .halted(halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    next_state = 3'b000; pc_we = 0; pc_sel = 0; pc_offset = 4'h0;
    addr_sel = 0; addr_offset = 4'h0; mem_sel = 0; mem_we_in = 0;
    alu_opcode = 3'b000; alu_sel_a = 0; alu_sel_b = 0; alu_we = 0; zf_we = 0;
    ir_we = 0; a_sel = 0; a_we = 0; b_sel = 0; b_we = 0; halt = 0;
  endtask

  task automatic poke(input logic [7:0] addr, input logic [7:0] data);
    tb_we = 1'b1; tb_addr = addr; tb_data = data;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Places v at Mem[pc], lets the MDR capture it, then writes it to A or B.
  task automatic load_reg(input bit to_b, input logic [7:0] v);
    poke(pc, v);
    tick();
    if (to_b) begin b_we = 1; b_sel = 0; end
    else      begin a_we = 1; a_sel = 0; end
    tick();
    idle();
  endtask

  task automatic set_pc(input logic [7:0] target);
    logic [7:0] diff;
    int n;
    n = 0;
    while (pc !== target && n < 300) begin
      diff = target - pc;
      pc_we = 1; pc_sel = 1;
      pc_offset = (diff > 8'd7) ? 4'd7 : diff[3:0];
      tick();
      n++;
    end
    pc_we = 0; pc_sel = 0; pc_offset = 4'h0;
    checks++;
    if (pc !== target) begin errors++; $display("FAIL set_pc: pc=%h expected %h", pc, target); end
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; mem_we_in = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    tick();
    reset = 1'b0; mem_we_in = 1'b0;
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL reset_state: got %h expected 0", state); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
    checks++; if (instr !== 8'h00) begin errors++; $display("FAIL reset_ir: got %h expected 00", instr); end
    checks++; if (reg_a !== 8'h00 || reg_b !== 8'h00) begin errors++; $display("FAIL reset_ab: got %h/%h expected 00/00", reg_a, reg_b); end
    checks++; if (zf !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags: zf=%b halted=%b expected 0/0", zf, halted); end
  endtask

  task automatic test_state();
    next_state = 3'b101; tick();
    checks++; if (state !== 3'b101) begin errors++; $display("FAIL state_load1: got %h expected 5", state); end
    next_state = 3'b010; tick();
    checks++; if (state !== 3'b010) begin errors++; $display("FAIL state_load2: got %h expected 2", state); end
    idle();
  endtask

  task automatic test_fetch();
    poke(8'h00, 8'h81);
    ir_we = 1; pc_we = 1; pc_sel = 0;
    tick(); idle();
    checks++; if (instr !== 8'h81) begin errors++; $display("FAIL fetch_ir: got %h expected 81", instr); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL fetch_pc: got %h expected 01", pc); end
  endtask

  task automatic test_alu();
    load_reg(0, 8'h05); load_reg(1, 8'hFB);
    checks++; if (reg_a !== 8'h05 || reg_b !== 8'hFB) begin errors++; $display("FAIL alu_setup: got %h/%h expected 05/FB", reg_a, reg_b); end
    alu_opcode = 3'b000; alu_sel_a = 0; alu_sel_b = 1; alu_we = 1; zf_we = 1;
    tick(); idle();
    checks++; if (zf !== 1'b1) begin errors++; $display("FAIL add_zf: got %b expected 1", zf); end
    a_sel = 1; a_we = 1; tick(); idle();
    checks++; if (reg_a !== 8'h00) begin errors++; $display("FAIL add_wb: got %h expected 00", reg_a); end

    load_reg(0, 8'h3C); load_reg(1, 8'hF0);
    alu_opcode = 3'b001; alu_sel_a = 0; alu_sel_b = 1; alu_we = 1; zf_we = 1;
    tick(); idle();
    checks++; if (zf !== 1'b0) begin errors++; $display("FAIL and_zf: got %b expected 0", zf); end
    b_sel = 1; b_we = 1; tick(); idle();
    checks++; if (reg_b !== 8'h30) begin errors++; $display("FAIL and_wb: got %h expected 30", reg_b); end

    alu_opcode = 3'b010; alu_sel_a = 1; alu_we = 1; zf_we = 1;
    tick(); idle();
    // Illegal opcode yields zero; A is written from the old ALU register (no bypass).
    alu_opcode = 3'b101; alu_we = 1; zf_we = 1; a_we = 1; a_sel = 1;
    tick(); idle();
    checks++; if (reg_a !== 8'hCF) begin errors++; $display("FAIL not_wb_nobypass: got %h expected CF", reg_a); end
    checks++; if (zf !== 1'b1) begin errors++; $display("FAIL illegal_zf: got %b expected 1", zf); end
    a_we = 1; a_sel = 1; tick(); idle();
    checks++; if (reg_a !== 8'h00) begin errors++; $display("FAIL illegal_wb: got %h expected 00", reg_a); end

    alu_opcode = 3'b000; alu_sel_a = 1; alu_sel_b = 1; alu_we = 1; zf_we = 1;
    tick(); idle();
    b_we = 1; b_sel = 1; tick(); idle();
    checks++; if (reg_b !== 8'h60 || zf !== 1'b0) begin errors++; $display("FAIL add_bb: got %h zf=%b expected 60 zf=0", reg_b, zf); end
  endtask

  task automatic test_load_neg();
    set_pc(8'h10);
    poke(8'h0E, 8'h3C);
    addr_sel = 1; addr_offset = 4'b1110;
    #1;
    checks++; if (mem_addr !== 8'h0E) begin errors++; $display("FAIL load_addr: got %h expected 0E", mem_addr); end
    tick();
    addr_sel = 0; addr_offset = 4'h0; b_we = 1; b_sel = 0;
    tick(); idle();
    checks++; if (reg_b !== 8'h3C) begin errors++; $display("FAIL load_wb: got %h expected 3C", reg_b); end
  endtask

  task automatic test_store();
    load_reg(1, 8'hA5);
    set_pc(8'h20);
    addr_sel = 1; addr_offset = 4'h2; mem_sel = 1; mem_we_in = 1;
    #1;
    checks++; if (mem_addr !== 8'h22 || mem_wdata !== 8'hA5 || mem_we !== 1'b1)
      begin errors++; $display("FAIL store_b_bus: got addr=%h data=%h we=%b expected 22/A5/1", mem_addr, mem_wdata, mem_we); end
    tick(); idle(); #1;
    checks++; if (mem_we !== 1'b0 || mem[8'h22] !== 8'hA5)
      begin errors++; $display("FAIL store_b_mem: got we=%b mem=%h expected 0/A5", mem_we, mem[8'h22]); end
    load_reg(0, 8'h5A);
    addr_sel = 1; addr_offset = 4'b1111; mem_sel = 0; mem_we_in = 1;
    #1;
    checks++; if (mem_addr !== 8'h1F || mem_wdata !== 8'h5A)
      begin errors++; $display("FAIL store_a_bus: got addr=%h data=%h expected 1F/5A", mem_addr, mem_wdata); end
    tick(); idle();
    checks++; if (mem[8'h1F] !== 8'h5A) begin errors++; $display("FAIL store_a_mem: got %h expected 5A", mem[8'h1F]); end
  endtask

  task automatic test_jump();
    do_reset();
    pc_we = 1; pc_sel = 1; pc_offset = 4'b1000; tick();
    checks++; if (pc !== 8'hF8) begin errors++; $display("FAIL jump_neg_wrap: got %h expected F8", pc); end
    set_pc(8'hFE);
    pc_we = 1; pc_sel = 1; pc_offset = 4'b0011; tick();
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL jump_pos_wrap: got %h expected 01", pc); end
    pc_offset = 4'b1110; tick();
    checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL jump_back: got %h expected FF", pc); end
    pc_sel = 0; tick(); idle();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL inc_wrap: got %h expected 00", pc); end
  endtask

  task automatic test_reset_mid();
    load_reg(0, 8'h42);
    set_pc(8'h05);
    poke(8'h05, 8'h77);
    reset = 1; a_we = 1; a_sel = 0; pc_we = 1; mem_we_in = 1; next_state = 3'b011;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b expected 0", mem_we); end
    tick();
    reset = 0; idle();
    checks++; if (reg_a !== 8'h00 || pc !== 8'h00 || state !== 3'b000)
      begin errors++; $display("FAIL rstmid_state: got a=%h pc=%h st=%h expected 00/00/0", reg_a, pc, state); end
    checks++; if (mem[8'h05] !== 8'h77) begin errors++; $display("FAIL rstmid_mem: got %h expected 77", mem[8'h05]); end
  endtask

  task automatic test_halt();
    poke(8'h00, 8'h99);
    tick();
    halt = 1; tick(); halt = 0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", halted); end
    pc_we = 1; a_we = 1; a_sel = 0; ir_we = 1; mem_we_in = 1; mem_sel = 0; next_state = 3'b110;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL halt_we: got %b expected 0", mem_we); end
    tick(); idle();
    checks++; if (pc !== 8'h00 || reg_a !== 8'h00 || instr !== 8'h00)
      begin errors++; $display("FAIL halt_freeze: got pc=%h a=%h ir=%h expected 00/00/00", pc, reg_a, instr); end
    checks++; if (mem[8'h00] !== 8'h99) begin errors++; $display("FAIL halt_mem: got %h expected 99", mem[8'h00]); end
    checks++; if (state !== 3'b110 || halted !== 1'b1)
      begin errors++; $display("FAIL halt_state: got st=%h halted=%b expected 6/1", state, halted); end
    do_reset();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b expected 0", halted); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_state();
    test_fetch();
    test_alu();
    test_load_neg();
    test_store();
    test_jump();
    test_reset_mid();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
